// File: rtl/cpu_pkg.sv
// +------------------------------------------------------------------+
// | cpu_pkg: shared widths, types and grant encodings. Rev 1.0        |
// +------------------------------------------------------------------+
`default_nettype none

package cpu_pkg;

  localparam int N            = 32;
  localparam int AW           = 4;
  localparam int NREG         = 16;
  localparam int MAX_INFLIGHT = 8;
  localparam int CW           = 4;

  // Bit positions of the one-hot writeback grant vector
  localparam int GNT_ALU = 0;
  localparam int GNT_MEM = 1;

  typedef logic [AW-1:0]   reg_idx_t;
  typedef logic [N-1:0]    word_t;
  typedef logic [NREG-1:0] reg_mask_t;
  typedef logic [CW-1:0]   count_t;

endpackage

`default_nettype wire

// File: rtl/regfile_wb_scheduler_if.sv
// +------------------------------------------------------------------+
// | regfile_wb_scheduler_if: issue, writeback and bank signals. Rev 1.0 |
// +------------------------------------------------------------------+
`default_nettype none

interface regfile_wb_scheduler_if;
  import cpu_pkg::*;

  logic      issue_valid;
  reg_idx_t  issue_d;
  reg_idx_t  issue_s1;
  reg_idx_t  issue_s2;
  logic      issue_ready;

  logic      alu_wb_valid;
  reg_idx_t  alu_wb_rd;
  word_t     alu_wb_data;
  logic      alu_wb_ready;

  logic      mem_wb_valid;
  reg_idx_t  mem_wb_rd;
  word_t     mem_wb_data;
  logic      mem_wb_ready;

  logic      wr_en;
  reg_idx_t  wr_addr;
  word_t     wr_data;
  reg_mask_t busy;
  count_t    inflight;
  logic      wb_err;

  modport master (
    output issue_valid, issue_d, issue_s1, issue_s2,
    output alu_wb_valid, alu_wb_rd, alu_wb_data,
    output mem_wb_valid, mem_wb_rd, mem_wb_data,
    input  issue_ready, alu_wb_ready, mem_wb_ready,
    input  wr_en, wr_addr, wr_data, busy, inflight, wb_err
  );

  modport slave (
    input  issue_valid, issue_d, issue_s1, issue_s2,
    input  alu_wb_valid, alu_wb_rd, alu_wb_data,
    input  mem_wb_valid, mem_wb_rd, mem_wb_data,
    output issue_ready, alu_wb_ready, mem_wb_ready,
    output wr_en, wr_addr, wr_data, busy, inflight, wb_err
  );

endinterface

`default_nettype wire

// File: rtl/rr_arbiter2.sv
// +------------------------------------------------------------------+
// | rr_arbiter2: two-requester round-robin, one-hot grant. Rev 1.0    |
// +------------------------------------------------------------------+
`default_nettype none

module rr_arbiter2
  import cpu_pkg::*;
(
  input  logic       clk,
  input  logic       rst,
  input  logic [1:0] req,
  output logic [1:0] gnt
);

  // Winner of the most recent contested cycle; reset value lets ALU win first
  logic r_last_mem;

  always_comb begin
    gnt = 2'b00;
    case (req)
      2'b01:   gnt[GNT_ALU] = 1'b1;
      2'b10:   gnt[GNT_MEM] = 1'b1;
      2'b11: begin
        gnt[GNT_ALU] = r_last_mem;
        gnt[GNT_MEM] = !r_last_mem;
      end
      default: gnt = 2'b00;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_last_mem <= 1'b1;
    end else if (req == 2'b11) begin
      r_last_mem <= gnt[GNT_MEM];
    end
  end

endmodule

`default_nettype wire

// File: rtl/regfile_wb_scheduler.sv
// +------------------------------------------------------------------+
// | regfile_wb_scheduler: busy scoreboard, issue gating, wb port. 1.0 |
// +------------------------------------------------------------------+
`default_nettype none

module regfile_wb_scheduler
  import cpu_pkg::*;
(
  input  logic                 clk,
  input  logic                 rst,
  regfile_wb_scheduler_if.slave bus
);

  localparam reg_mask_t c_ONE_HOT0 = reg_mask_t'(1);

  logic      r_wr_en;
  reg_idx_t  r_wr_addr;
  word_t     r_wr_data;
  reg_mask_t r_busy;
  count_t    r_inflight;
  logic      r_wb_err;

  logic [1:0] w_req;
  logic [1:0] w_gnt;
  logic       w_gnt_any;
  logic       w_gnt_ok;
  reg_idx_t   w_gnt_rd;
  word_t      w_gnt_data;
  logic       w_issue_ready;
  logic       w_issue_fire;
  reg_mask_t  w_set;
  reg_mask_t  w_clr;
  count_t     w_inflight_nxt;

  assign w_req[GNT_ALU] = bus.alu_wb_valid;
  assign w_req[GNT_MEM] = bus.mem_wb_valid;

  rr_arbiter2 u_arb (
    .clk (clk),
    .rst (rst),
    .req (w_req),
    .gnt (w_gnt)
  );

  assign w_gnt_any  = |w_gnt;
  assign w_gnt_rd   = w_gnt[GNT_MEM] ? bus.mem_wb_rd   : bus.alu_wb_rd;
  assign w_gnt_data = w_gnt[GNT_MEM] ? bus.mem_wb_data : bus.alu_wb_data;
  // A grant to a register nobody is waiting on is consumed but never written
  assign w_gnt_ok   = w_gnt_any && r_busy[w_gnt_rd];

  assign w_issue_ready = !r_busy[bus.issue_s1] && !r_busy[bus.issue_s2] &&
                         !r_busy[bus.issue_d] &&
                         (r_inflight < count_t'(MAX_INFLIGHT));
  assign w_issue_fire  = bus.issue_valid && w_issue_ready;

  assign w_set = w_issue_fire ? (c_ONE_HOT0 << bus.issue_d) : '0;
  assign w_clr = r_wr_en      ? (c_ONE_HOT0 << r_wr_addr)   : '0;

  always_comb begin
    w_inflight_nxt = r_inflight;
    case ({w_issue_fire, r_wr_en})
      2'b10:   w_inflight_nxt = r_inflight + count_t'(1);
      2'b01:   w_inflight_nxt = r_inflight - count_t'(1);
      default: w_inflight_nxt = r_inflight;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_wr_en    <= 1'b0;
      r_wr_addr  <= '0;
      r_wr_data  <= '0;
      r_busy     <= '0;
      r_inflight <= '0;
      r_wb_err   <= 1'b0;
    end else begin
      r_wr_en <= w_gnt_ok;
      if (w_gnt_ok) begin
        r_wr_addr <= w_gnt_rd;
        r_wr_data <= w_gnt_data;
      end
      if (w_gnt_any && !w_gnt_ok) begin
        r_wb_err <= 1'b1;
      end
      r_busy     <= (r_busy & ~w_clr) | w_set;
      r_inflight <= w_inflight_nxt;
    end
  end

  assign bus.issue_ready  = w_issue_ready;
  assign bus.alu_wb_ready = w_gnt[GNT_ALU];
  assign bus.mem_wb_ready = w_gnt[GNT_MEM];
  assign bus.wr_en        = r_wr_en;
  assign bus.wr_addr      = r_wr_addr;
  assign bus.wr_data      = r_wr_data;
  assign bus.busy         = r_busy;
  assign bus.inflight     = r_inflight;
  assign bus.wb_err       = r_wb_err;

endmodule

`default_nettype wire

// File: tb/tb_regfile_wb_scheduler.sv
// +------------------------------------------------------------------+
// | tb_regfile_wb_scheduler: directed checks of the wb scheduler. 1.0 |
// +------------------------------------------------------------------+
`default_nettype none

module tb_regfile_wb_scheduler;

  logic clk = 1'b0;
  logic rst = 1'b0;
  int   total = 0;
  int   bad   = 0;

  regfile_wb_scheduler_if bus ();

  regfile_wb_scheduler dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_inputs();
    bus.issue_valid  = 1'b0;
    bus.issue_d      = 4'd0;
    bus.issue_s1     = 4'd0;
    bus.issue_s2     = 4'd0;
    bus.alu_wb_valid = 1'b0;
    bus.alu_wb_rd    = 4'd0;
    bus.alu_wb_data  = 32'd0;
    bus.mem_wb_valid = 1'b0;
    bus.mem_wb_rd    = 4'd0;
    bus.mem_wb_data  = 32'd0;
  endtask

  task automatic do_reset();
    idle_inputs();
    rst = 1'b1;
    tick();
    rst = 1'b0;
    #1;
  endtask

  task automatic issue_one(input logic [3:0] d);
    bus.issue_valid = 1'b1;
    bus.issue_d     = d;
    bus.issue_s1    = 4'd0;
    bus.issue_s2    = 4'd0;
    tick();
    bus.issue_valid = 1'b0;
  endtask

  task automatic test_reset();
    do_reset();
    total++; if (bus.busy !== 16'h0000) begin bad++; $display("FAIL rst_busy got=%h exp=0000", bus.busy); end
    total++; if (bus.inflight !== 4'd0) begin bad++; $display("FAIL rst_inflight got=%0d exp=0", bus.inflight); end
    total++; if (bus.wr_en !== 1'b0) begin bad++; $display("FAIL rst_wr_en got=%b exp=0", bus.wr_en); end
    total++; if (bus.wb_err !== 1'b0) begin bad++; $display("FAIL rst_wb_err got=%b exp=0", bus.wb_err); end
    bus.issue_valid = 1'b1; bus.issue_d = 4'd3; bus.issue_s1 = 4'd1; bus.issue_s2 = 4'd2;
    #1;
    total++; if (bus.issue_ready !== 1'b1) begin bad++; $display("FAIL rst_issue_ready got=%b exp=1", bus.issue_ready); end
    tick();
    bus.issue_valid = 1'b0;
    total++; if (bus.busy !== 16'h0008) begin bad++; $display("FAIL issue_busy got=%h exp=0008", bus.busy); end
    total++; if (bus.inflight !== 4'd1) begin bad++; $display("FAIL issue_inflight got=%0d exp=1", bus.inflight); end
  endtask

  task automatic test_raw_stall();
    // reg 3 is still busy from test_reset
    bus.issue_valid = 1'b1; bus.issue_d = 4'd4; bus.issue_s1 = 4'd3; bus.issue_s2 = 4'd0;
    bus.alu_wb_valid = 1'b1; bus.alu_wb_rd = 4'd3; bus.alu_wb_data = 32'hDEADBEEF;
    #1;
    total++; if (bus.issue_ready !== 1'b0) begin bad++; $display("FAIL raw_ready_t got=%b exp=0", bus.issue_ready); end
    total++; if (bus.alu_wb_ready !== 1'b1) begin bad++; $display("FAIL raw_alu_gnt got=%b exp=1", bus.alu_wb_ready); end
    tick();
    bus.alu_wb_valid = 1'b0;
    total++; if (bus.wr_en !== 1'b1) begin bad++; $display("FAIL raw_wr_en got=%b exp=1", bus.wr_en); end
    total++; if (bus.wr_addr !== 4'd3) begin bad++; $display("FAIL raw_wr_addr got=%0d exp=3", bus.wr_addr); end
    total++; if (bus.wr_data !== 32'hDEADBEEF) begin bad++; $display("FAIL raw_wr_data got=%h exp=deadbeef", bus.wr_data); end
    total++; if (bus.issue_ready !== 1'b0) begin bad++; $display("FAIL raw_ready_t1 got=%b exp=0", bus.issue_ready); end
    tick();
    total++; if (bus.busy !== 16'h0000) begin bad++; $display("FAIL raw_busy_t2 got=%h exp=0000", bus.busy); end
    total++; if (bus.issue_ready !== 1'b1) begin bad++; $display("FAIL raw_ready_t2 got=%b exp=1", bus.issue_ready); end
    total++; if (bus.inflight !== 4'd0) begin bad++; $display("FAIL raw_inflight got=%0d exp=0", bus.inflight); end
    bus.issue_valid = 1'b0;
  endtask

  task automatic test_contention();
    do_reset();
    issue_one(4'd5);
    issue_one(4'd6);
    bus.alu_wb_valid = 1'b1; bus.alu_wb_rd = 4'd5; bus.alu_wb_data = 32'h1111_0005;
    bus.mem_wb_valid = 1'b1; bus.mem_wb_rd = 4'd6; bus.mem_wb_data = 32'h2222_0006;
    #1;
    total++; if (bus.alu_wb_ready !== 1'b1) begin bad++; $display("FAIL cont_alu_t got=%b exp=1", bus.alu_wb_ready); end
    total++; if (bus.mem_wb_ready !== 1'b0) begin bad++; $display("FAIL cont_mem_t got=%b exp=0", bus.mem_wb_ready); end
    tick();
    bus.alu_wb_valid = 1'b0;
    #1;
    total++; if (bus.mem_wb_ready !== 1'b1) begin bad++; $display("FAIL cont_mem_t1 got=%b exp=1", bus.mem_wb_ready); end
    total++; if (bus.wr_en !== 1'b1 || bus.wr_addr !== 4'd5 || bus.wr_data !== 32'h1111_0005) begin
      bad++; $display("FAIL cont_wr1 got=%b/%0d/%h exp=1/5/11110005", bus.wr_en, bus.wr_addr, bus.wr_data); end
    tick();
    bus.mem_wb_valid = 1'b0;
    total++; if (bus.wr_en !== 1'b1 || bus.wr_addr !== 4'd6 || bus.wr_data !== 32'h2222_0006) begin
      bad++; $display("FAIL cont_wr2 got=%b/%0d/%h exp=1/6/22220006", bus.wr_en, bus.wr_addr, bus.wr_data); end
    tick();
    total++; if (bus.wr_en !== 1'b0 || bus.wr_addr !== 4'd6) begin
      bad++; $display("FAIL cont_hold got=%b/%0d exp=0/6", bus.wr_en, bus.wr_addr); end
    total++; if (bus.busy !== 16'h0000 || bus.inflight !== 4'd0) begin
      bad++; $display("FAIL cont_drain got=%h/%0d exp=0000/0", bus.busy, bus.inflight); end
  endtask

  task automatic test_round_robin();
    logic [3:0] alu_rds [4];
    logic [3:0] mem_rds [4];
    logic [3:0] prev_rd;
    int ai;
    int mi;
    alu_rds = '{4'd1, 4'd3, 4'd5, 4'd7};
    mem_rds = '{4'd2, 4'd4, 4'd6, 4'd8};
    ai = 0; mi = 0; prev_rd = 4'd0;
    do_reset();
    for (int r = 1; r <= 8; r++) issue_one(4'(r));
    for (int k = 0; k < 6; k++) begin
      bus.alu_wb_valid = 1'b1; bus.alu_wb_rd = alu_rds[ai]; bus.alu_wb_data = 32'hA000_0000 + 32'(ai);
      bus.mem_wb_valid = 1'b1; bus.mem_wb_rd = mem_rds[mi]; bus.mem_wb_data = 32'hB000_0000 + 32'(mi);
      #1;
      if (k > 0) begin
        total++; if (bus.wr_en !== 1'b1 || bus.wr_addr !== prev_rd) begin
          bad++; $display("FAIL rr_write%0d got=%b/%0d exp=1/%0d", k, bus.wr_en, bus.wr_addr, prev_rd); end
      end
      total++; if (bus.alu_wb_ready !== (k % 2 == 0) || bus.mem_wb_ready !== (k % 2 == 1)) begin
        bad++; $display("FAIL rr_grant%0d got=alu%b,mem%b exp=alu%b,mem%b", k,
                        bus.alu_wb_ready, bus.mem_wb_ready, (k % 2 == 0), (k % 2 == 1)); end
      if (k % 2 == 0) begin prev_rd = alu_rds[ai]; ai++; end
      else            begin prev_rd = mem_rds[mi]; mi++; end
      tick();
    end
    bus.alu_wb_valid = 1'b0; bus.mem_wb_valid = 1'b0;
    total++; if (bus.wr_en !== 1'b1 || bus.wr_addr !== 4'd6) begin
      bad++; $display("FAIL rr_last_write got=%b/%0d exp=1/6", bus.wr_en, bus.wr_addr); end
    tick();
    total++; if (bus.busy !== 16'h0180 || bus.inflight !== 4'd2) begin
      bad++; $display("FAIL rr_residue got=%h/%0d exp=0180/2", bus.busy, bus.inflight); end
  endtask

  task automatic test_full_same_edge();
    do_reset();
    for (int r = 1; r <= 8; r++) issue_one(4'(r));
    bus.issue_d = 4'd9; bus.issue_s1 = 4'd0; bus.issue_s2 = 4'd0;
    #1;
    total++; if (bus.inflight !== 4'd8 || bus.busy !== 16'h01FE) begin
      bad++; $display("FAIL full_count got=%0d/%h exp=8/01fe", bus.inflight, bus.busy); end
    total++; if (bus.issue_ready !== 1'b0) begin bad++; $display("FAIL full_ready got=%b exp=0", bus.issue_ready); end
    bus.alu_wb_valid = 1'b1; bus.alu_wb_rd = 4'd1; bus.alu_wb_data = 32'h0000_0001;
    tick();
    bus.alu_wb_rd = 4'd2; bus.alu_wb_data = 32'h0000_0002;
    #1;
    total++; if (bus.issue_ready !== 1'b0 || bus.inflight !== 4'd8) begin
      bad++; $display("FAIL full_wr1 got=%b/%0d exp=0/8", bus.issue_ready, bus.inflight); end
    tick();
    bus.alu_wb_valid = 1'b0;
    bus.issue_valid = 1'b1; bus.issue_d = 4'd9;
    #1;
    total++; if (bus.inflight !== 4'd7 || bus.issue_ready !== 1'b1 || bus.wr_en !== 1'b1) begin
      bad++; $display("FAIL same_pre got=%0d/%b/%b exp=7/1/1", bus.inflight, bus.issue_ready, bus.wr_en); end
    tick();
    total++; if (bus.inflight !== 4'd7 || bus.busy !== 16'h03F8) begin
      bad++; $display("FAIL same_edge got=%0d/%h exp=7/03f8", bus.inflight, bus.busy); end
    bus.issue_d = 4'd10;
    tick();
    bus.issue_valid = 1'b0;
    bus.issue_d = 4'd11;
    #1;
    total++; if (bus.inflight !== 4'd8 || bus.issue_ready !== 1'b0) begin
      bad++; $display("FAIL refill got=%0d/%b exp=8/0", bus.inflight, bus.issue_ready); end
  endtask

  task automatic test_error_reset();
    do_reset();
    bus.alu_wb_valid = 1'b1; bus.alu_wb_rd = 4'd9; bus.alu_wb_data = 32'h0BAD_0009;
    #1;
    total++; if (bus.alu_wb_ready !== 1'b1) begin bad++; $display("FAIL err_gnt got=%b exp=1", bus.alu_wb_ready); end
    tick();
    bus.alu_wb_valid = 1'b0;
    total++; if (bus.wb_err !== 1'b1 || bus.wr_en !== 1'b0 || bus.inflight !== 4'd0) begin
      bad++; $display("FAIL err_flag got=%b/%b/%0d exp=1/0/0", bus.wb_err, bus.wr_en, bus.inflight); end
    issue_one(4'd2);
    bus.alu_wb_valid = 1'b1; bus.alu_wb_rd = 4'd2; bus.alu_wb_data = 32'h0000_0022;
    tick();
    bus.alu_wb_valid = 1'b0;
    total++; if (bus.wr_en !== 1'b1 || bus.busy !== 16'h0004 || bus.wb_err !== 1'b1) begin
      bad++; $display("FAIL err_pre got=%b/%h/%b exp=1/0004/1", bus.wr_en, bus.busy, bus.wb_err); end
    #2;
    rst = 1'b1;
    #1;
    total++; if (bus.wb_err !== 1'b0 || bus.wr_en !== 1'b0 || bus.busy !== 16'h0000 || bus.inflight !== 4'd0) begin
      bad++; $display("FAIL async_rst got=%b/%b/%h/%0d exp=0/0/0000/0", bus.wb_err, bus.wr_en, bus.busy, bus.inflight); end
    tick();
    rst = 1'b0;
  endtask

  initial begin
    idle_inputs();
    test_reset();
    test_raw_stall();
    test_contention();
    test_round_robin();
    test_full_same_edge();
    test_error_reset();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

`default_nettype wire
